ppm_decoder_multi: RTL and testbench

Parametrised successor to the 8-channel PPM decoder. Decodes one PPM pulse train into NUM_CH channel widths and regenerates them as servo pulses on io pins. Adds the following, none of which the fixed decoder has:
- selectable input polarity
- sync-gap detection
- per-frame validation with glitch rejection
- signal-loss failsafe
- readable width registers

Sits behind the wrapper on io_in/buf_io_out, clocked by wb_clk_i.

---
 rtl/ppm_decoder_multi.sv | 133 +++++++++++++
 tb/tb_ppm_decoder_multi.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ppm_decoder_multi.sv
// PPM pulse-train decoder: validates frames of NUM_CH channel intervals, latches
// them into width registers and regenerates them as servo pulses, with a loss failsafe.
//
// state  | meaning
// HUNT   | waiting for a sync gap; channel and bad intervals are ignored
// ACTIVE | synced; channel intervals are collected into the shadow set
module ppm_decoder_multi #(
  parameter int NUM_CH  = 8,
  parameter int CNT_W   = 20,
  parameter int MIN_W   = 8400,
  parameter int MAX_W   = 27600,
  parameter int SYNC_W  = 36000,
  parameter int TIMEOUT = 300000
) (
  input  logic                      wb_clk_i,
  input  logic                      wb_rst_ni,
  input  logic                      ppm_i,
  input  logic                      invert_i,
  output logic [NUM_CH*CNT_W-1:0]   ch_width_o,
  output logic [NUM_CH-1:0]         ch_out_o,
  output logic                      frame_valid_o,
  output logic                      locked_o,
  output logic                      lost_o
);

  localparam int IDX_W = $clog2(NUM_CH + 1);
  localparam logic [CNT_W-1:0] MIN_C  = CNT_W'(MIN_W);
  localparam logic [CNT_W-1:0] MAX_C  = CNT_W'(MAX_W);
  localparam logic [CNT_W-1:0] SYNC_C = CNT_W'(SYNC_W);
  localparam logic [CNT_W-1:0] TO_C   = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] SAT_C  = '1;
  localparam logic [IDX_W-1:0] FULL_C = IDX_W'(NUM_CH);

  typedef enum logic {HUNT, ACTIVE} state_t;

  state_t           state;
  logic             ppm_s1, ppm_s2, lvl_d;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] shadow [NUM_CH];
  logic [CNT_W-1:0] regen_cnt;
  logic             regen_active;

  logic lvl, act_edge, is_sync, is_ch, timeout_hit;

  // Polarity is applied after the synchroniser so the edge detector always sees rising = active.
  assign lvl         = ppm_s2 ^ invert_i;
  assign act_edge    = lvl & ~lvl_d;
  assign is_sync     = (cnt >= SYNC_C);
  assign is_ch       = (cnt >= MIN_C) && (cnt <= MAX_C);
  assign timeout_hit = (cnt == TO_C);

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state         <= HUNT;
      ppm_s1        <= 1'b0;
      ppm_s2        <= 1'b0;
      lvl_d         <= 1'b0;
      cnt           <= '0;
      idx           <= '0;
      regen_cnt     <= '0;
      regen_active  <= 1'b0;
      ch_width_o    <= '0;
      ch_out_o      <= '0;
      frame_valid_o <= 1'b0;
      locked_o      <= 1'b0;
      lost_o        <= 1'b0;
      for (int i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else begin
      ppm_s1        <= ppm_i;
      ppm_s2        <= ppm_s1;
      lvl_d         <= lvl;
      frame_valid_o <= 1'b0;

      if (act_edge)        cnt <= CNT_W'(1);
      else if (cnt != SAT_C) cnt <= cnt + 1'b1;

      if (regen_active) begin
        if (regen_cnt == MAX_C) regen_active <= 1'b0;
        else                    regen_cnt    <= regen_cnt + 1'b1;
      end
      for (int i = 0; i < NUM_CH; i++)
        ch_out_o[i] <= regen_active && (regen_cnt < ch_width_o[i*CNT_W +: CNT_W]);

      if (act_edge) begin
        case (state)
          HUNT: begin
            if (is_sync) begin
              state <= ACTIVE;
              idx   <= '0;
            end
          end
          ACTIVE: begin
            if (is_sync) begin
              idx <= '0;
              if (idx == FULL_C) begin
                for (int i = 0; i < NUM_CH; i++) ch_width_o[i*CNT_W +: CNT_W] <= shadow[i];
                frame_valid_o <= 1'b1;
                locked_o      <= 1'b1;
                lost_o        <= 1'b0;
                regen_cnt     <= '0;
                regen_active  <= 1'b1;
              end else begin
                locked_o <= 1'b0;
              end
            end else if (is_ch) begin
              if (idx == FULL_C) begin
                state    <= HUNT;
                locked_o <= 1'b0;
              end else begin
                for (int i = 0; i < NUM_CH; i++)
                  if (idx == IDX_W'(i)) shadow[i] <= cnt;
                idx <= idx + 1'b1;
              end
            end else begin
              state    <= HUNT;
              locked_o <= 1'b0;
            end
          end
          default: state <= HUNT;
        endcase
      end else if (timeout_hit) begin
        // An edge on the same clock has already been served above, so it suppresses the failsafe.
        lost_o       <= 1'b1;
        locked_o     <= 1'b0;
        state        <= HUNT;
        regen_active <= 1'b0;
        ch_out_o     <= '0;
      end
    end
  end

endmodule

// File: tb/tb_ppm_decoder_multi.sv
// Bench for ppm_decoder_multi at scaled-down timing: an interval-level model of the
// frame rules is checked every cycle, plus literal checks on widths, pulses and timeouts.
module tb_ppm_decoder_multi;

  localparam int NUM_CH  = 8;
  localparam int CNT_W   = 13;
  localparam int MIN_W   = 84;
  localparam int MAX_W   = 276;
  localparam int SYNC_W  = 360;
  localparam int TIMEOUT = 3000;
  localparam int SYNC_IV = 400;
  localparam int PW      = 20;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ppm = 1'b0;
  logic inv = 1'b0;
  logic [NUM_CH*CNT_W-1:0] ch_width;
  logic [NUM_CH-1:0]       ch_out;
  logic frame_valid, locked, lost;

  always #5 clk = ~clk;

  ppm_decoder_multi #(
    .NUM_CH(NUM_CH), .CNT_W(CNT_W), .MIN_W(MIN_W), .MAX_W(MAX_W),
    .SYNC_W(SYNC_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .ppm_i(ppm), .invert_i(inv),
    .ch_width_o(ch_width), .ch_out_o(ch_out), .frame_valid_o(frame_valid),
    .locked_o(locked), .lost_o(lost)
  );

  int n_chk = 0;
  int n_fail = 0;
  int hi0 = 0;
  int fv_cnt = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // What the DUT sampled on each rising edge
  logic smp_ppm = 1'b0;
  logic smp_rst = 1'b0;
  always @(posedge clk) begin
    smp_ppm <= ppm;
    smp_rst <= rst_n;
  end

  // Model: time-stamped intervals between active edges, frame list as a queue
  int m_n;
  bit m_hist[$];
  int m_last;
  bit m_active;
  int m_ch[$];
  int m_w[NUM_CH];
  int m_latch;
  bit m_regen, m_locked, m_lost, m_fv;

  function automatic bit lv(input int k);
    return ((k < 0) ? 1'b0 : m_hist[k]) ^ inv;
  endfunction

  task automatic model_reset();
    m_n = -1;
    m_hist.delete();
    m_last = 0;
    m_active = 1'b0;
    m_ch.delete();
    for (int i = 0; i < NUM_CH; i++) m_w[i] = 0;
    m_latch = 0;
    m_regen = 1'b0;
    m_locked = 1'b0;
    m_lost = 1'b0;
    m_fv = 1'b0;
  endtask

  task automatic model_step();
    int iv;
    bit edge_seen;
    m_n++;
    m_hist.push_back(smp_ppm);
    m_fv = 1'b0;
    iv = m_n - m_last;
    if (iv > CNT_MAX) iv = CNT_MAX;
    edge_seen = (m_n >= 1) && lv(m_n - 2) && !lv(m_n - 3);
    if (edge_seen) begin
      m_last = m_n;
      if (!m_active) begin
        if (iv >= SYNC_W) begin
          m_active = 1'b1;
          m_ch.delete();
        end
      end else if (iv >= SYNC_W) begin
        if (m_ch.size() == NUM_CH) begin
          for (int i = 0; i < NUM_CH; i++) m_w[i] = m_ch[i];
          m_fv = 1'b1;
          m_locked = 1'b1;
          m_lost = 1'b0;
          m_latch = m_n;
          m_regen = 1'b1;
        end else begin
          m_locked = 1'b0;
        end
        m_ch.delete();
      end else if (iv >= MIN_W && iv <= MAX_W) begin
        if (m_ch.size() < NUM_CH) m_ch.push_back(iv);
        else begin
          m_active = 1'b0;
          m_locked = 1'b0;
        end
      end else begin
        m_active = 1'b0;
        m_locked = 1'b0;
      end
    end else if (iv == TIMEOUT) begin
      m_lost = 1'b1;
      m_locked = 1'b0;
      m_active = 1'b0;
      m_regen = 1'b0;
    end
  endtask

  initial begin
    logic [NUM_CH*CNT_W-1:0] exp_w;
    logic [NUM_CH-1:0] exp_o;
    int age;
    model_reset();
    forever begin
      @(negedge clk);
      if (!rst_n) model_reset();
      else if (smp_rst) model_step();
      age = m_n - m_latch;
      for (int i = 0; i < NUM_CH; i++) begin
        exp_w[i*CNT_W +: CNT_W] = CNT_W'(m_w[i]);
        exp_o[i] = m_regen && (age >= 1) && (age <= m_w[i]);
      end
      chk("ch_width", 128'(ch_width), 128'(exp_w));
      chk("ch_out", 128'(ch_out), 128'(exp_o));
      chk("frame_valid", 128'(frame_valid), 128'(m_fv));
      chk("locked", 128'(locked), 128'(m_locked));
      chk("lost", 128'(lost), 128'(m_lost));
      if (ch_out[0]) hi0++;
      if (frame_valid) fv_cnt++;
    end
  end

  int cw[NUM_CH];

  task automatic tick(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic send_interval(input int iv);
    ppm = ~inv;
    tick(PW);
    ppm = inv;
    tick(iv - PW);
  endtask

  task automatic send_frame(input int nch);
    send_interval(SYNC_IV);
    for (int i = 0; i < nch; i++) send_interval(cw[i]);
  endtask

  task automatic set_cw(input int base, input int step);
    for (int i = 0; i < NUM_CH; i++) cw[i] = base + step * i;
  endtask

  function automatic logic [127:0] w_of(input int ch);
    return 128'(ch_width[ch*CNT_W +: CNT_W]);
  endfunction

  task automatic check_t1_widths(input string tag);
    logic [NUM_CH*CNT_W-1:0] lit;
    for (int i = 0; i < NUM_CH; i++) lit[i*CNT_W +: CNT_W] = CNT_W'(120 + 12 * i);
    chk({tag, "_widths"}, 128'(ch_width), 128'(lit));
  endtask

  task automatic run_two_frames(input string tag);
    set_cw(120, 12);
    send_interval(30);
    send_frame(NUM_CH);
    hi0 = 0;
    fv_cnt = 0;
    send_frame(NUM_CH);
    chk({tag, "_fv_count"}, 128'(fv_cnt), 128'd1);
    chk({tag, "_locked"}, 128'(locked), 128'd1);
    chk({tag, "_w0"}, w_of(0), 128'd120);
    chk({tag, "_w7"}, w_of(7), 128'd204);
    check_t1_widths(tag);
    chk({tag, "_ch0_high_clocks"}, 128'(hi0), 128'd120);
  endtask

  initial begin
    int cyc_lost;
    tick(4);
    chk("reset_width", 128'(ch_width), 128'd0);
    chk("reset_flags", 128'({ch_out, frame_valid, locked, lost}), 128'd0);
    rst_n = 1'b1;
    tick(10);

    // 1: normal polarity
    run_two_frames("t1");

    // 2: inverted polarity, changed only under reset
    rst_n = 1'b0;
    tick(3);
    inv = 1'b1;
    ppm = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    run_two_frames("t2");

    // 3: 36-clock glitch mid-frame
    send_interval(SYNC_IV);
    send_interval(120);
    fv_cnt = 0;
    send_interval(132);
    send_interval(36);
    for (int i = 2; i < NUM_CH; i++) send_interval(120 + 12 * i);
    chk("t3_locked_after_glitch", 128'(locked), 128'd0);
    chk("t3_no_fv", 128'(fv_cnt), 128'd0);
    check_t1_widths("t3_retained");
    set_cw(130, 10);
    send_frame(NUM_CH);
    chk("t3_no_fv_hunt", 128'(fv_cnt), 128'd0);
    send_frame(NUM_CH);
    chk("t3_relock_fv", 128'(fv_cnt), 128'd1);
    chk("t3_relock", 128'(locked), 128'd1);
    chk("t3_w0", w_of(0), 128'd130);
    chk("t3_w7", w_of(7), 128'd200);

    // 4: six-channel frame
    set_cw(150, 8);
    send_frame(6);
    fv_cnt = 0;
    send_frame(NUM_CH);
    chk("t4_short_no_fv", 128'(fv_cnt), 128'd0);
    chk("t4_short_unlocked", 128'(locked), 128'd0);
    chk("t4_short_w0", w_of(0), 128'd130);
    send_frame(NUM_CH);
    chk("t4_latch_fv", 128'(fv_cnt), 128'd1);
    chk("t4_locked", 128'(locked), 128'd1);
    chk("t4_w0", w_of(0), 128'd150);
    chk("t4_w7", w_of(7), 128'd206);

    // 5: signal loss after one last edge
    cyc_lost = 0;
    ppm = ~inv;
    for (int c = 1; c <= 3600; c++) begin
      @(negedge clk);
      if (c == PW) ppm = inv;
      if (lost && cyc_lost == 0) cyc_lost = c;
    end
    tick(1);
    chk("t5_lost_delay", 128'(cyc_lost), 128'(TIMEOUT + 4));
    chk("t5_lost", 128'(lost), 128'd1);
    chk("t5_unlocked", 128'(locked), 128'd0);
    chk("t5_ch_out", 128'(ch_out), 128'd0);
    chk("t5_w0_held", w_of(0), 128'd150);
    send_frame(NUM_CH);
    send_frame(NUM_CH);
    chk("t5_lost_cleared", 128'(lost), 128'd0);
    chk("t5_relock", 128'(locked), 128'd1);

    // 6: reset during channel 4
    send_interval(SYNC_IV);
    for (int i = 0; i < 4; i++) send_interval(cw[i]);
    ppm = ~inv;
    tick(PW);
    ppm = inv;
    tick(30);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_width", 128'(ch_width), 128'd0);
    chk("t6_rst_flags", 128'({ch_out, frame_valid, locked, lost}), 128'd0);
    tick(5);
    rst_n = 1'b1;
    tick(10);
    send_frame(NUM_CH);
    chk("t6_hunt_unlocked", 128'(locked), 128'd0);
    fv_cnt = 0;
    send_frame(NUM_CH);
    chk("t6_lock", 128'(locked), 128'd1);
    chk("t6_fv", 128'(fv_cnt), 128'd1);
    chk("t6_w0", w_of(0), 128'd150);

    tick(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
